// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detects NUM_IRQ lines into pending, masks and prioritises them,
// and runs a REQ/SERVICE handshake with the control unit. Optional macro INTC_SYNC_EN adds 2-flop input sync.
module int_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               int_ack_i,
  input  logic               reti_i,
  output logic               int_req_o,
  output logic [VEC_W-1:0]   int_vec_o,
  output logic               in_service_o,
  input  logic               port_stb_i,
  input  logic               port_we_i,
  input  logic [1:0]         port_addr_i,
  input  logic [7:0]         port_wdata_i,
  output logic [7:0]         port_rdata_o,
  output logic               port_ack_o
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state;
  state_t             state_next;
  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] irq_edge;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] w1c_clr;
  logic [VEC_W-1:0]   win_idx;
  logic               any_active;
  logic               take_ack;
  logic               stb_q;
  logic               accept;
  logic               wr_en;
  logic [7:0]         rd_mux;
  logic [7:0]         status;

  // Input sampling: stage boundary between the asynchronous irq_i and the clk domain
`ifdef INTC_SYNC_EN
  logic [NUM_IRQ-1:0] irq_meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_meta <= '0;
      irq_s    <= '0;
    end else begin
      irq_meta <= irq_i;
      irq_s    <= irq_meta;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_s <= '0;
    end else begin
      irq_s <= irq_i;
    end
  end
`endif

  assign irq_edge   = irq_s & ~irq_q;
  assign active     = pending & mask;
  assign any_active = |active;

  // Lowest index wins, so scan from the top and let lower hits overwrite
  always_comb begin
    win_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) win_idx = VEC_W'(i);
    end
  end

  // A held strobe is accepted only on its first cycle
  assign accept = port_stb_i & ~stb_q;
  assign wr_en  = accept & port_we_i;

  always_comb begin
    w1c_clr = '0;
    if (wr_en && port_addr_i == 2'd1) w1c_clr = port_wdata_i[NUM_IRQ-1:0];
  end

  always_comb begin
    ack_clr = '0;
    if (take_ack) ack_clr[win_idx] = 1'b1;
  end

  always_comb begin
    state_next = state;
    take_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (any_active) state_next = REQ;
      end
      REQ: begin
        if (!any_active) begin
          state_next = IDLE;
        end else if (int_ack_i) begin
          state_next = SERVICE;
          take_ack   = 1'b1;
        end
      end
      SERVICE: begin
        if (reti_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    status             = '0;
    status[7]          = in_service_o;
    status[VEC_W-1:0]  = int_vec_o;
  end

  always_comb begin
    rd_mux = '0;
    case (port_addr_i)
      2'd0:    rd_mux = 8'(mask);
      2'd1:    rd_mux = 8'(pending);
      2'd2:    rd_mux = status;
      default: rd_mux = '0;
    endcase
  end

  // Register stage: edge history, pending/mask, FSM and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q        <= '0;
      pending      <= '0;
      mask         <= '0;
      state        <= IDLE;
      int_req_o    <= 1'b0;
      int_vec_o    <= '0;
      in_service_o <= 1'b0;
      stb_q        <= 1'b0;
      port_ack_o   <= 1'b0;
      port_rdata_o <= '0;
    end else begin
      irq_q        <= irq_s;
      // A fresh edge beats any clear landing on the same bit
      pending      <= (pending & ~(ack_clr | w1c_clr)) | irq_edge;
      if (wr_en && port_addr_i == 2'd0) mask <= port_wdata_i[NUM_IRQ-1:0];
      state        <= state_next;
      int_req_o    <= (state_next == REQ);
      in_service_o <= (state_next == SERVICE);
      if (take_ack) int_vec_o <= win_idx;
      stb_q        <= port_stb_i;
      port_ack_o   <= accept;
      port_rdata_o <= accept ? rd_mux : 8'h00;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: handshake, priority, masking, withdraw, collision and async reset.
module tb_int_ctrl;

`ifdef INTC_SYNC_EN
  localparam int N = 3;
`else
  localparam int N = 2;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] irq_i;
  logic       int_ack_i;
  logic       reti_i;
  logic       int_req_o;
  logic [2:0] int_vec_o;
  logic       in_service_o;
  logic       port_stb_i;
  logic       port_we_i;
  logic [1:0] port_addr_i;
  logic [7:0] port_wdata_i;
  logic [7:0] port_rdata_o;
  logic       port_ack_o;

  int n_chk;
  int n_pass;
  logic [7:0] rd;

  int_ctrl dut (
    .clk(clk), .rst(rst), .irq_i(irq_i), .int_ack_i(int_ack_i), .reti_i(reti_i),
    .int_req_o(int_req_o), .int_vec_o(int_vec_o), .in_service_o(in_service_o),
    .port_stb_i(port_stb_i), .port_we_i(port_we_i), .port_addr_i(port_addr_i),
    .port_wdata_i(port_wdata_i), .port_rdata_o(port_rdata_o), .port_ack_o(port_ack_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic port_wr(input logic [1:0] addr, input logic [7:0] data);
    port_stb_i = 1'b1; port_we_i = 1'b1; port_addr_i = addr; port_wdata_i = data;
    tick();
    chk("wr_ack", port_ack_o, 1'b1);
    port_stb_i = 1'b0; port_we_i = 1'b0;
    tick();
  endtask

  task automatic port_rd(input logic [1:0] addr, output logic [7:0] data);
    port_stb_i = 1'b1; port_we_i = 1'b0; port_addr_i = addr;
    tick();
    data = port_rdata_o;
    port_stb_i = 1'b0;
    tick();
  endtask

  task automatic pulse_irq(input logic [7:0] bits);
    irq_i = bits;
    tick();
    irq_i = '0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; irq_i = '0; int_ack_i = 0; reti_i = 0;
    port_stb_i = 0; port_we_i = 0; port_addr_i = '0; port_wdata_i = '0;
    #2 rst = 1'b0;
    #2;
    chk("rst_req", int_req_o, 0);
    chk("rst_vec", int_vec_o, 0);
    chk("rst_insvc", in_service_o, 0);
    chk("rst_ack", port_ack_o, 0);
    chk("rst_rdata", port_rdata_o, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // single source, basic handshake
    port_wr(2'd0, 8'h05);
    pulse_irq(8'h04);
    repeat (N - 1) tick();
    chk("t1_req_early", int_req_o, 0);
    tick();
    chk("t1_req", int_req_o, 1);
    int_ack_i = 1; tick(); int_ack_i = 0;
    chk("t1_vec", int_vec_o, 2);
    chk("t1_insvc", in_service_o, 1);
    chk("t1_req_svc", int_req_o, 0);
    port_rd(2'd1, rd); chk("t1_pending", rd, 8'h00);
    port_rd(2'd2, rd); chk("t1_status", rd, 8'h82);
    reti_i = 1; tick(); reti_i = 0;
    chk("t1_reti_insvc", in_service_o, 0);
    chk("t1_reti_vec", int_vec_o, 2);

    // two simultaneous sources, lowest index first
    port_wr(2'd0, 8'hFF);
    pulse_irq(8'h42);
    repeat (N) tick();
    chk("t2_req", int_req_o, 1);
    int_ack_i = 1; tick(); int_ack_i = 0;
    chk("t2_vec1", int_vec_o, 1);
    reti_i = 1; tick(); reti_i = 0;
    chk("t2_req_after_reti", int_req_o, 0);
    tick();
    chk("t2_req_rearm", int_req_o, 1);
    int_ack_i = 1; tick(); int_ack_i = 0;
    chk("t2_vec6", int_vec_o, 6);
    reti_i = 1; tick(); reti_i = 0;
    tick();
    chk("t2_idle", int_req_o, 0);

    // masked source becomes visible on mask write
    port_wr(2'd0, 8'h00);
    pulse_irq(8'h08);
    repeat (N + 2) tick();
    chk("t3_req_masked", int_req_o, 0);
    port_rd(2'd1, rd); chk("t3_pending", rd, 8'h08);
    port_stb_i = 1; port_we_i = 1; port_addr_i = 2'd0; port_wdata_i = 8'h08;
    tick();
    chk("t3_req_wedge", int_req_o, 0);
    port_stb_i = 0; port_we_i = 0;
    tick();
    chk("t3_req", int_req_o, 1);
    int_ack_i = 1; tick(); int_ack_i = 0;
    chk("t3_vec", int_vec_o, 3);
    reti_i = 1; tick(); reti_i = 0;

    // withdraw by W1C while requesting; late ack ignored
    port_wr(2'd0, 8'h01);
    pulse_irq(8'h01);
    repeat (N) tick();
    chk("t4_req", int_req_o, 1);
    port_stb_i = 1; port_we_i = 1; port_addr_i = 2'd1; port_wdata_i = 8'h01;
    tick();
    port_stb_i = 0; port_we_i = 0;
    tick();
    chk("t4_req_drop", int_req_o, 0);
    int_ack_i = 1; tick(); int_ack_i = 0;
    chk("t4_late_ack_insvc", in_service_o, 0);
    chk("t4_late_ack_req", int_req_o, 0);
    port_rd(2'd2, rd); chk("t4_status", rd, 8'h03);

    // held strobe gives one ack
    port_stb_i = 1; port_we_i = 0; port_addr_i = 2'd0;
    tick(); chk("hold_ack1", port_ack_o, 1); chk("hold_rdata", port_rdata_o, 8'h01);
    tick(); chk("hold_ack2", port_ack_o, 0);
    tick(); chk("hold_ack3", port_ack_o, 0);
    port_stb_i = 0; tick();

    // held level sets pending only once
    port_wr(2'd0, 8'h00);
    irq_i = 8'h20;
    repeat (N + 1) tick();
    port_rd(2'd1, rd); chk("lvl_pending", rd, 8'h20);
    port_wr(2'd1, 8'h20);
    repeat (3) tick();
    port_rd(2'd1, rd); chk("lvl_no_reset", rd, 8'h00);
    irq_i = '0; repeat (N + 1) tick();

    // collision: new edge on bit 4 on the ack edge that clears it
    port_wr(2'd0, 8'h10);
    pulse_irq(8'h10);
    repeat (N) tick();
    chk("t5_req", int_req_o, 1);
    irq_i = 8'h10; tick(); irq_i = '0;
    repeat (N - 2) tick();
    int_ack_i = 1; tick(); int_ack_i = 0;
    chk("t5_vec", int_vec_o, 4);
    chk("t5_insvc", in_service_o, 1);
    port_rd(2'd1, rd); chk("t5_pending", rd, 8'h10);
    reti_i = 1; tick(); reti_i = 0;
    tick();
    chk("t5_rearm", int_req_o, 1);
    int_ack_i = 1; tick(); int_ack_i = 0;
    chk("t5_svc2", in_service_o, 1);

    // asynchronous reset during service
    #2 rst = 1'b0;
    #1;
    chk("ar_req", int_req_o, 0);
    chk("ar_vec", int_vec_o, 0);
    chk("ar_insvc", in_service_o, 0);
    chk("ar_ack", port_ack_o, 0);
    chk("ar_rdata", port_rdata_o, 0);
    tick();
    rst = 1'b1;
    tick();
    port_rd(2'd0, rd); chk("ar_mask", rd, 8'h00);
    port_rd(2'd1, rd); chk("ar_pending", rd, 8'h00);
    port_rd(2'd3, rd); chk("addr3", rd, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller that sits directly upstream of the control unit. It collects `NUM_IRQ` external interrupt lines, detects rising edges and latches them as pending, and masks and prioritises them. It drives the control unit's `int_req` input, and consumes the control unit's `int_ack_o` and `reti_o` pulses to move through request, service and return. Software reads and writes its mask and pending registers through the port (IN/OUT) bus.

## Interface
Parameters:
- `NUM_IRQ`, default 8, number of interrupt sources (2..8).
- `VEC_W`, default `$clog2(NUM_IRQ)`, width of the vector output.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `irq_i`  in  `NUM_IRQ`  external interrupt lines; asynchronous; rising-edge sensitive.
- `int_ack_i`  in  1  one-cycle acknowledge from the control unit's INT state.
- `reti_i`  in  1  one-cycle return-from-interrupt from the control unit's decode stage.
- `int_req_o`  out  1  interrupt request to the control unit.
- `int_vec_o`  out  `VEC_W`  index of the source being serviced.
- `in_service_o`  out  1  a handler is active.
- `port_stb_i`  in  1  port bus strobe.
- `port_we_i`  in  1  port bus write enable.
- `port_addr_i`  in  2  register select.
- `port_wdata_i`  in  8  write data.
- `port_rdata_o`  out  8  read data.
- `port_ack_o`  out  1  port bus acknowledge.

## Operation
- Edge detect: `irq_q` holds the previous sampled level. A source has an edge when `sampled & ~irq_q`. Each edge sets its bit in `pending`.
- Masking: `active = pending & mask`. Priority goes to the lowest index.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE goes to REQ when `active != 0`.
  - REQ goes to SERVICE on `int_ack_i`. On that edge the controller:
    - latches `int_vec_o` with the winning index;
    - clears that pending bit;
    - sets `in_service_o`.
  - REQ goes back to IDLE, with no acknowledge, if `active` becomes 0 (mask write or W1C clear).
  - SERVICE goes to IDLE on `reti_i`, which clears `in_service_o`. `int_vec_o` holds its value.
- `int_req_o` is registered and equals `state == REQ`. There is no nesting: `int_req_o` stays low throughout SERVICE.
- `int_ack_i` outside REQ is ignored. `reti_i` outside SERVICE is ignored.
- Register map (`port_addr_i`), with bits above `NUM_IRQ` reading 0:
  - 0: `mask`, read/write.
  - 1: `pending`, read; writing 1 to a bit clears it.
  - 2: status, read-only: `{in_service_o, 4'b0, int_vec_o}` for VEC_W=3.
  - 3: reads 0; writes are ignored.
- Simultaneous events on one pending bit: a new edge wins over an ack-clear and over a W1C clear, so the bit stays set.
- Mask writes take effect on the cycle after the write edge.

## Timing
- Reset values: `mask`=0, `pending`=0, `irq_q`=0, synchronizers=0, state IDLE, `int_req_o`=0, `int_vec_o`=0, `in_service_o`=0, `port_ack_o`=0, `port_rdata_o`=0.
- Reset asserted mid-operation returns to IDLE immediately. Pending and in-service state are lost.
- Latency from an `irq_i` rise, when the source is unmasked and the FSM is idle:
  - pending is set at edge N (N=3 with `INTC_SYNC_EN`, N=2 without);
  - `int_req_o` rises at edge N+1.
- After `reti_i`, a remaining active source raises `int_req_o` 2 edges later (IDLE, then REQ).
- Port bus:
  - `port_ack_o` pulses 1 cycle, on the edge after `port_stb_i`, for exactly one cycle per strobe.
  - Write data is committed on the strobe edge.
  - `port_rdata_o` is registered and valid while `port_ack_o` is high.
  - Holding `port_stb_i` high across several cycles gives a single ack. Another ack needs the strobe to go low first.
- Level held high produces exactly one pending set. A new edge needs the level to drop for at least 1 sampled cycle.

## Configuration
- `INTC_SYNC_EN` defined: each `irq_i` bit passes through a 2-flop synchronizer before edge detect.
- `INTC_SYNC_EN` undefined: `irq_i` is sampled by a single flop only. Use this only when the sources are synchronous to `clk`. Every latency above drops by 1 cycle.

## Test plan
- Reset, then write mask=0x05. Pulse `irq_i[2]`. Then `int_req_o`=1 at edge N+1. Send `int_ack_i`. Then `int_vec_o`=2, `in_service_o`=1, `pending`=0x00.
- Edges on `irq_i[1]` and `irq_i[6]` in the same cycle, mask=0xFF. The first ack gives vector 1. After `reti_i`, `int_req_o` rises 2 cycles later. The second ack gives vector 6.
- Masked source: mask=0x00, pulse `irq_i[3]`. Then `pending`=0x08 and `int_req_o` stays 0. Write mask=0x08. `int_req_o`=1 two edges later.
- Withdraw: while in REQ for source 0, W1C write 0x01 to address 1. Then `int_req_o` drops next cycle, state is IDLE, and a late `int_ack_i` is ignored.
- Collision: a new edge on bit 4 on the same edge as the ack that clears bit 4. Then `pending[4]` stays 1 and `int_req_o` re-asserts after `reti_i`.
- Assert reset asynchronously during SERVICE. All outputs go to 0 immediately, without waiting for a clock edge.
